// File: rtl/excess2_seq_ctrl_if.sv
// Purpose: board-side signal bundle between the switch/button inputs, the
//          excess-2 sequencing controller and the code converter.
// Signals:
//   sw[3:0]        raw switch code, bit 3 = A (MSB)
//   btn_load       raw asynchronous load button, active high
//   btn_mode       raw asynchronous mode button, active high
//   code_out[3:0]  registered code to the converter, bit 3 = A
//   blank          registered, 1 when code_out is not a valid excess-2 code
//   state[1:0]     registered FSM state: 00 MANUAL, 01 AUTO, 10 PAUSE
//   step_tick      one-cycle pulse when code_out changes due to an auto step
// Modports: master drives the raw inputs, slave is the controller.
interface excess2_seq_ctrl_if;
    logic [3:0] sw;
    logic       btn_load;
    logic       btn_mode;
    logic [3:0] code_out;
    logic       blank;
    logic [1:0] state;
    logic       step_tick;

    modport master (
        output sw, btn_load, btn_mode,
        input  code_out, blank, state, step_tick
    );

    modport slave (
        input  sw, btn_load, btn_mode,
        output code_out, blank, state, step_tick
    );
endinterface

// File: rtl/excess2_seq_ctrl.sv
// Purpose: sequencing controller for the excess-2 code converter. Debounces
//          the load and mode buttons, latches the switch code on a load
//          press, and either holds that code (MANUAL), auto-steps through the
//          ten valid codes 0010..1011 (AUTO) or freezes the sequence (PAUSE).
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   io_bus  excess2_seq_ctrl_if.slave (sw, buttons in; code/blank/state/tick out)
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized cycles before a button change is accepted (>=1)
//   STEP_CYCLES      clock cycles per auto step (>=2)
module excess2_seq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned STEP_CYCLES     = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    excess2_seq_ctrl_if.slave     io_bus
);

    localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned STEP_W    = $clog2(STEP_CYCLES);
    localparam int unsigned N_BTN     = 2;
    localparam int unsigned BTN_LOAD  = 0;
    localparam int unsigned BTN_MODE  = 1;
    localparam logic [3:0]  CODE_MIN  = 4'b0010;
    localparam logic [3:0]  CODE_LAST = 4'b1010;
    localparam logic [3:0]  CODE_MAX  = 4'b1011;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'b00,
        ST_AUTO   = 2'b01,
        ST_PAUSE  = 2'b10
    } state_t;

    // Outside 0010..1011 the converter output is meaningless.
    function automatic logic f_blank(input logic [3:0] code);
        return (code < CODE_MIN) || (code > CODE_MAX);
    endfunction

    // Advance within the valid range; 1011 and any invalid code go to 0010.
    function automatic logic [3:0] f_step(input logic [3:0] code);
        return ((code >= CODE_MIN) && (code <= CODE_LAST)) ? (code + 4'd1) : CODE_MIN;
    endfunction

    logic [N_BTN-1:0] w_btn_raw;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_db_lvl;
    logic [N_BTN-1:0] r_press;
    logic [DB_W-1:0]  r_db_cnt [N_BTN];

    state_t           r_state;
    logic [3:0]       r_code;
    logic             r_blank;
    logic             r_step_tick;
    logic [STEP_W-1:0] r_step_cnt;

    logic             w_load_press;
    logic             w_mode_press;
    logic             w_step_done;
    logic [3:0]       w_code_step;

    assign w_btn_raw    = {io_bus.btn_mode, io_bus.btn_load};
    assign w_load_press = r_press[BTN_LOAD];
    assign w_mode_press = r_press[BTN_MODE];
    assign w_step_done  = (r_step_cnt == STEP_W'(STEP_CYCLES - 1));
    assign w_code_step  = f_step(r_code);

    // Button path: 2-flop synchronizer, mismatch-run counter, debounced level
    // and a one-cycle press pulse on accepted 0->1 transitions only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db_lvl <= '0;
            r_press  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                    r_press[i]  <= 1'b0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    // This sample is the DEBOUNCE_CYCLES-th consecutive mismatch.
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                    r_press[i]  <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    r_press[i]  <= 1'b0;
                end
            end
        end
    end

    // Mode FSM with registered code/blank/tick; load press always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_MANUAL;
            r_code      <= CODE_MIN;
            r_blank     <= 1'b0;
            r_step_tick <= 1'b0;
            r_step_cnt  <= '0;
        end else begin
            r_step_tick <= 1'b0;
            case (r_state)
                ST_MANUAL: begin
                    if (w_load_press) begin
                        r_code  <= io_bus.sw;
                        r_blank <= f_blank(io_bus.sw);
                    end else if (w_mode_press) begin
                        r_state    <= ST_AUTO;
                        r_step_cnt <= '0;
                    end
                end
                ST_AUTO: begin
                    if (w_load_press) begin
                        r_code     <= io_bus.sw;
                        r_blank    <= f_blank(io_bus.sw);
                        r_state    <= ST_MANUAL;
                        r_step_cnt <= '0;
                    end else begin
                        if (w_step_done) begin
                            r_code      <= w_code_step;
                            r_blank     <= f_blank(w_code_step);
                            r_step_tick <= 1'b1;
                            r_step_cnt  <= '0;
                        end else begin
                            r_step_cnt <= r_step_cnt + STEP_W'(1);
                        end
                        // A step coinciding with the pause press is still taken.
                        if (w_mode_press) begin
                            r_state <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_load_press) begin
                        r_code  <= io_bus.sw;
                        r_blank <= f_blank(io_bus.sw);
                        r_state <= ST_MANUAL;
                    end else if (w_mode_press) begin
                        r_state <= ST_AUTO;
                    end
                end
                default: begin
                    r_state <= ST_MANUAL;
                end
            endcase
        end
    end

    assign io_bus.code_out  = r_code;
    assign io_bus.blank     = r_blank;
    assign io_bus.state     = 2'(r_state);
    assign io_bus.step_tick = r_step_tick;

endmodule

// File: tb/tb_excess2_seq_ctrl.sv
// Purpose: self-checking bench for excess2_seq_ctrl with a cycle-level
//          behavioural reference model, directed scenarios and random buttons.
module tb_excess2_seq_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned STEP = 8;

    logic clk = 1'b0;
    logic rst;

    excess2_seq_ctrl_if bus ();

    excess2_seq_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .STEP_CYCLES     (STEP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: raw-sample delay line, debounced levels with the
    // edge index of the last agreement, press pulses and the sequencer.
    logic [1:0] m_pipe[$];
    bit         m_lvl   [2];
    int         m_agree [2];
    bit         m_prs   [2];
    int         m_cyc;
    int         m_state;   // 0 MANUAL, 1 AUTO, 2 PAUSE
    int         m_code;
    int         m_cnt;
    bit         m_tick;

    function automatic bit blank_of(input int c);
        return (c < 2) || (c > 11);
    endfunction

    function automatic int next_code(input int c);
        if (c >= 2 && c <= 10) return c + 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_pipe.delete();
        m_pipe.push_back(2'b00);
        m_pipe.push_back(2'b00);
        for (int i = 0; i < 2; i++) begin
            m_lvl[i]   = 1'b0;
            m_agree[i] = m_cyc;
            m_prs[i]   = 1'b0;
        end
        m_state = 0;
        m_code  = 2;
        m_cnt   = 0;
        m_tick  = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0] s;
        bit pl;
        bit pm;
        m_cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        pl = m_prs[0];
        pm = m_prs[1];
        m_tick = 1'b0;
        case (m_state)
            0: begin
                if (pl) m_code = int'(bus.sw);
                else if (pm) begin m_state = 1; m_cnt = 0; end
            end
            1: begin
                if (pl) begin
                    m_code = int'(bus.sw); m_state = 0; m_cnt = 0;
                end else begin
                    if (m_cnt == STEP - 1) begin
                        m_code = next_code(m_code); m_tick = 1'b1; m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                    if (pm) m_state = 2;
                end
            end
            default: begin
                if (pl) begin m_code = int'(bus.sw); m_state = 0; end
                else if (pm) m_state = 1;
            end
        endcase
        s = m_pipe.pop_front();
        m_pipe.push_back({bus.btn_mode, bus.btn_load});
        for (int i = 0; i < 2; i++) begin
            m_prs[i] = 1'b0;
            if (s[i] == m_lvl[i]) begin
                m_agree[i] = m_cyc;
            end else if (m_cyc - m_agree[i] >= DEB) begin
                m_lvl[i]   = s[i];
                m_agree[i] = m_cyc;
                m_prs[i]   = s[i];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("code_out",  32'(bus.code_out),  32'(m_code));
        chk("blank",     32'(bus.blank),     32'(blank_of(m_code)));
        chk("state",     32'(bus.state),     32'(m_state));
        chk("step_tick", 32'(bus.step_tick), 32'(m_tick));
    endtask

    task automatic press(input bit ld, input bit md, input int hold);
        bus.btn_load = ld;
        bus.btn_mode = md;
        repeat (hold) step();
        bus.btn_load = 1'b0;
        bus.btn_mode = 1'b0;
        repeat (8) step();
    endtask

    // Raise mode, run until the press has acted, then release (no settle).
    task automatic mode_edge();
        bus.btn_mode = 1'b1;
        repeat (7) step();
        bus.btn_mode = 1'b0;
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            step();
            n++;
            if (bus.step_tick) break;
        end
        chk("tick_seen", 32'(bus.step_tick), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_code"},  32'(bus.code_out),  32'h2);
        chk({tag, "_blank"}, 32'(bus.blank),     32'h0);
        chk({tag, "_state"}, 32'(bus.state),     32'h0);
        chk({tag, "_tick"},  32'(bus.step_tick), 32'h0);
    endtask

    initial begin
        int n;
        int frozen;
        int rem [2];
        bit lvl [2];

        m_cyc = 0;
        rst = 1'b1;
        bus.sw = 4'h0;
        bus.btn_load = 1'b0;
        bus.btn_mode = 1'b0;
        model_reset();
        #3;
        chk_reset_outputs("por");
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // Manual load and glitch rejection
        bus.sw = 4'b0101;
        press(1'b1, 1'b0, 10);
        chk("load_code",  32'(bus.code_out), 32'h5);
        chk("load_blank", 32'(bus.blank),    32'h0);
        bus.sw = 4'b1001;
        press(1'b1, 1'b0, 3);
        chk("glitch_code", 32'(bus.code_out), 32'h5);

        // Auto wrap 1010 -> 1011 -> 0010 -> 0011
        bus.sw = 4'b1010;
        press(1'b1, 1'b0, 10);
        mode_edge();
        chk("auto_state", 32'(bus.state), 32'h1);
        wait_tick(20, n);
        chk("first_gap", 32'(n), 32'd8);
        chk("wrap1", 32'(bus.code_out), 32'hb);
        wait_tick(20, n);
        chk("period1", 32'(n), 32'd8);
        chk("wrap2", 32'(bus.code_out), 32'h2);
        wait_tick(20, n);
        chk("period2", 32'(n), 32'd8);
        chk("wrap3", 32'(bus.code_out), 32'h3);

        // Invalid code recovery
        bus.sw = 4'b1110;
        press(1'b1, 1'b0, 10);
        chk("inv_blank", 32'(bus.blank),    32'h1);
        chk("inv_state", 32'(bus.state),    32'h0);
        chk("inv_code",  32'(bus.code_out), 32'he);
        mode_edge();
        wait_tick(20, n);
        chk("recover_code",  32'(bus.code_out), 32'h2);
        chk("recover_blank", 32'(bus.blank),    32'h0);

        // Pause with the step counter holding 5, then resume
        repeat (6) step();
        mode_edge();
        chk("pause_state", 32'(bus.state), 32'h2);
        frozen = m_code;
        repeat (22) step();
        chk("pause_code",   32'(bus.code_out), 32'(frozen));
        chk("pause_state2", 32'(bus.state),    32'h2);
        mode_edge();
        chk("resume_state", 32'(bus.state), 32'h1);
        wait_tick(20, n);
        chk("resume_gap", 32'(n), 32'd3);

        // Load and mode pressed together in AUTO
        bus.sw = 4'b0100;
        bus.btn_load = 1'b1;
        bus.btn_mode = 1'b1;
        repeat (7) step();
        chk("simul_state", 32'(bus.state),     32'h0);
        chk("simul_code",  32'(bus.code_out),  32'h4);
        chk("simul_tick",  32'(bus.step_tick), 32'h0);
        bus.btn_load = 1'b0;
        bus.btn_mode = 1'b0;
        repeat (8) step();

        // Random buttons and switches against the model
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0;
            lvl[i] = 1'b0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = 1'($urandom_range(0, 1));
                    rem[i] = int'($urandom_range(1, 12));
                end
                rem[i]--;
            end
            bus.btn_load = lvl[0];
            bus.btn_mode = lvl[1];
            bus.sw = 4'($urandom);
            step();
        end
        bus.btn_load = 1'b0;
        bus.btn_mode = 1'b0;
        repeat (10) step();

        // Asynchronous reset mid-AUTO with code 0111
        bus.sw = 4'b0110;
        press(1'b1, 1'b0, 10);
        mode_edge();
        wait_tick(20, n);
        chk("pre_rst_code", 32'(bus.code_out), 32'h7);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        bus.btn_mode = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("post_rst_state", 32'(bus.state),    32'h0);
        chk("post_rst_code",  32'(bus.code_out), 32'h2);
        // Mode button held through reset release is accepted once stable
        repeat (9) step();
        chk("held_mode_state", 32'(bus.state), 32'h1);
        bus.btn_mode = 1'b0;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
